epp_bus_bridge: RTL and testbench
=================================

// Module: epp_bus_bridge
// PURPOSE
//  Host-side bridge from the Digilent EPP USB parallel interface (astb/dstb/write/db/wait) to the 8-bit control bus.
//  The control bus feeds instr_memory for program download and the bus-attached debug registers.
//  Sits directly upstream of instr_memory: host address cycles set a bus pointer; host data cycles become bus_write/bus_read transactions.
//  All EPP inputs are asynchronous to mclk and are synchronised inside this block.
// PARAMETERS
//  SYNC_STAGES   2   flops per synchroniser on astb/dstb/write (>=2)
//  READ_LATENCY  2   mclk cycles bus_read is held before bus_data is sampled (>=1)
//  AUTO_INC      0   1: bus address register += 1 (mod 256) after every data cycle
// PORTS
//  mclk       in     1  system clock, rising edge
//  rst_n      in     1  asynchronous active-low reset
//  usb_write  in     1  EPP direction, low = host write, high = host read
//  usb_astb   in     1  EPP address strobe, active low
//  usb_dstb   in     1  EPP data strobe, active low
//  usb_db     inout  8  EPP data; driven only during host read cycles, else Z
//  usb_wait   out    1  EPP wait/ack, high = cycle complete
//  bus_addr   out    8  control bus address (= address register)
//  bus_read   out    1  control bus read strobe, active high
//  bus_write  out    1  control bus write strobe, active high, exactly 1 cycle
//  bus_data   inout  8  control bus data; driven by bridge only while bus_write=1, else Z
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; addr_reg=0; bus_read=bus_write=0; usb_wait=0; usb_db and bus_data Z; sync flops reset to 1 (strobes inactive).
//  Sync: astb_s, dstb_s, write_s = SYNC_STAGES-flop versions; usb_db sampled on the cycle a strobe is first seen low (data is stable by EPP rule).
//  FSM states, encodings in parameters.vh:
//   IDLE: astb_s=0,dstb_s=1 -> write_s? ADDR_RD : ADDR_WR; dstb_s=0,astb_s=1 -> write_s? DATA_RD : DATA_WR; both low -> stay IDLE (illegal, ignored).
//   ADDR_WR: addr_reg <= captured db -> ACK.
//   ADDR_RD: rd_reg <= addr_reg -> ACK.
//   DATA_WR: drive bus_data=captured db, bus_write=1 for this single cycle -> ACK.
//   DATA_RD: bus_read=1 for READ_LATENCY cycles (counter); on the last cycle rd_reg <= bus_data -> ACK; bus_read drops on entry to ACK.
//   ACK: usb_wait=1; usb_db drives rd_reg iff the cycle was a read; wait for the active strobe_s=1 -> RELEASE.
//   RELEASE: usb_wait=0, usb_db Z; AUTO_INC and cycle was data -> addr_reg+1 (255 wraps to 0) -> IDLE.
//  Latency (strobe pin low to usb_wait high): write = SYNC_STAGES+2 cycles; data read = SYNC_STAGES+1+READ_LATENCY.
//  usb_wait rises only after the bus side completes; it falls within 2 cycles of strobe_s release.
//  Address-read cycles never touch the bus; address-write cycles never pulse bus_write.
//  Strobe released early (before ACK): the transaction still completes; ACK then sees the strobe high and proceeds straight to RELEASE.
//  No new cycle is accepted until RELEASE -> IDLE; a strobe still held low in IDLE after RELEASE would start a new cycle, but EPP forbids this.
//  rst_n low mid-cycle: abort at once, all outputs to reset values; the host will time out.
//  bus_data and usb_db are never both driven by the bridge in the same cycle.
// STRUCTURE
//  parameters.vh: EPP_IDLE..EPP_RELEASE state localparams.
//  Sub-module sync_bit (SYNC_STAGES flop chain, async reset to 1), instanced 3x.
//  FSM, address/data registers and tristate enables stay in this module.
// TESTING
//  Addr write 0x5A then addr read -> bus_addr=0x5A, usb_db=0x5A while wait=1, no bus_read/bus_write pulse.
//  Data write 0xC3 at addr 0x10 -> exactly one bus_write cycle with bus_addr=0x10, bus_data=0xC3; usb_wait high after SYNC_STAGES+2 cycles.
//  Data read, bus model returns 0x7E at READ_LATENCY -> bus_read held READ_LATENCY cycles, usb_db=0x7E until dstb released.
//  AUTO_INC=1: addr 0xFF, two data writes -> bus_addr 0xFF then 0x00.
//  astb and dstb asserted together -> no state change, usb_wait stays 0.
//  rst_n low during DATA_RD -> bus_read=0, usb_wait=0, both tristates Z the next sample; then a normal cycle succeeds.

Source files
------------

// File: rtl/epp_bus_bridge_pkg.sv
// rtl/epp_bus_bridge_pkg.sv - shared types and constants for the EPP to control-bus bridge
package epp_bus_bridge_pkg;

    localparam int DB_W = 8;

    typedef enum logic [2:0] {
        EPP_IDLE    = 3'd0,
        EPP_ADDR_WR = 3'd1,
        EPP_ADDR_RD = 3'd2,
        EPP_DATA_WR = 3'd3,
        EPP_DATA_RD = 3'd4,
        EPP_ACK     = 3'd5,
        EPP_RELEASE = 3'd6
    } epp_state_e;

endpackage

// File: rtl/epp_bus_bridge_sync_bit.sv
// rtl/epp_bus_bridge_sync_bit.sv - multi-flop synchroniser that resets to the inactive (high) level
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/epp_bus_bridge.sv
// rtl/epp_bus_bridge.sv - EPP host interface to 8-bit control bus bridge
module epp_bus_bridge
    import epp_bus_bridge_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int READ_LATENCY = 2,
    parameter bit AUTO_INC     = 1'b0
) (
    input  logic            mclk,
    input  logic            rst_n,
    input  logic            usb_write,
    input  logic            usb_astb,
    input  logic            usb_dstb,
    inout  wire  [DB_W-1:0] usb_db,
    output logic            usb_wait,
    output logic [DB_W-1:0] bus_addr,
    output logic            bus_read,
    output logic            bus_write,
    inout  wire  [DB_W-1:0] bus_data
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_LATENCY - 1);

    logic astb_s, dstb_s, write_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_astb (
        .clk(mclk), .rst_n(rst_n), .d_i(usb_astb), .q_o(astb_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dstb (
        .clk(mclk), .rst_n(rst_n), .d_i(usb_dstb), .q_o(dstb_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_write (
        .clk(mclk), .rst_n(rst_n), .d_i(usb_write), .q_o(write_s)
    );

    epp_state_e      state_q, state_d;
    logic [DB_W-1:0] addr_q, addr_d;
    logic [DB_W-1:0] rd_q, rd_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rd_q, is_rd_d;
    logic            is_data_q, is_data_d;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EPP_IDLE;
            addr_q    <= '0;
            rd_q      <= '0;
            db_q      <= '0;
            cnt_q     <= '0;
            is_rd_q   <= 1'b0;
            is_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            is_rd_q   <= is_rd_d;
            is_data_q <= is_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        is_rd_d   = is_rd_q;
        is_data_d = is_data_q;
        case (state_q)
            EPP_IDLE: begin
                // Both strobes low together is not a legal EPP cycle; it is ignored.
                if (!astb_s && dstb_s) begin
                    db_d      = usb_db;
                    is_rd_d   = write_s;
                    is_data_d = 1'b0;
                    state_d   = write_s ? EPP_ADDR_RD : EPP_ADDR_WR;
                end else if (astb_s && !dstb_s) begin
                    db_d      = usb_db;
                    is_rd_d   = write_s;
                    is_data_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = write_s ? EPP_DATA_RD : EPP_DATA_WR;
                end
            end
            EPP_ADDR_WR: begin
                addr_d  = db_q;
                state_d = EPP_ACK;
            end
            EPP_ADDR_RD: begin
                rd_d    = addr_q;
                state_d = EPP_ACK;
            end
            EPP_DATA_WR: begin
                state_d = EPP_ACK;
            end
            EPP_DATA_RD: begin
                if (cnt_q == RD_LAST) begin
                    rd_d    = bus_data;
                    state_d = EPP_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EPP_ACK: begin
                // An early-released strobe is already high here, so the cycle finishes at once.
                if (is_data_q ? dstb_s : astb_s) begin
                    state_d = EPP_RELEASE;
                end
            end
            EPP_RELEASE: begin
                if (AUTO_INC && is_data_q) begin
                    addr_d = addr_q + DB_W'(1);
                end
                state_d = EPP_IDLE;
            end
            default: begin
                state_d = EPP_IDLE;
            end
        endcase
    end

    // Bus and host data drivers are enabled in disjoint states, so they never overlap.
    assign usb_wait  = (state_q == EPP_ACK);
    assign bus_read  = (state_q == EPP_DATA_RD);
    assign bus_write = (state_q == EPP_DATA_WR);
    assign bus_addr  = addr_q;
    assign usb_db    = (state_q == EPP_ACK && is_rd_q) ? rd_q : {DB_W{1'bz}};
    assign bus_data  = bus_write ? db_q : {DB_W{1'bz}};

endmodule

// File: tb/tb_epp_bus_bridge.sv
// tb/tb_epp_bus_bridge.sv - scoreboard bench for epp_bus_bridge (plain and auto-increment instances)
module tb_epp_bus_bridge;

    localparam int S  = 2;
    localparam int RL = 2;

    typedef struct {
        int         lat;
        int         n_wr;
        int         n_rd;
        int         rel_cyc;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] wr_addr1;
        logic [7:0] rd_val;
        logic [7:0] db_idle;
        bit         rd_hold_ok;
    } obs_t;

    typedef struct {
        int         lat;
        int         n_wr;
        int         n_rd;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] rd_val;
        bit         is_read;
    } exp_t;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       usb_write = 1'b0;
    logic       usb_astb = 1'b1;
    logic       usb_dstb = 1'b1;
    logic [7:0] host_db = 8'h00;
    logic       host_oe = 1'b0;
    logic [7:0] bm_val = 8'h00;

    wire  [7:0] usb_db0, usb_db1, bus_data0, bus_data1;
    logic       usb_wait0, usb_wait1, bus_read0, bus_read1, bus_write0, bus_write1;
    logic [7:0] bus_addr0, bus_addr1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 mclk = ~mclk;

    assign usb_db0   = host_oe   ? host_db : 8'hzz;
    assign usb_db1   = host_oe   ? host_db : 8'hzz;
    assign bus_data0 = bus_read0 ? bm_val  : 8'hzz;
    assign bus_data1 = bus_read1 ? bm_val  : 8'hzz;

    epp_bus_bridge #(.SYNC_STAGES(S), .READ_LATENCY(RL), .AUTO_INC(1'b0)) dut (
        .mclk(mclk), .rst_n(rst_n), .usb_write(usb_write), .usb_astb(usb_astb),
        .usb_dstb(usb_dstb), .usb_db(usb_db0), .usb_wait(usb_wait0), .bus_addr(bus_addr0),
        .bus_read(bus_read0), .bus_write(bus_write0), .bus_data(bus_data0)
    );

    epp_bus_bridge #(.SYNC_STAGES(S), .READ_LATENCY(RL), .AUTO_INC(1'b1)) dut_inc (
        .mclk(mclk), .rst_n(rst_n), .usb_write(usb_write), .usb_astb(usb_astb),
        .usb_dstb(usb_dstb), .usb_db(usb_db1), .usb_wait(usb_wait1), .bus_addr(bus_addr1),
        .bus_read(bus_read1), .bus_write(bus_write1), .bus_data(bus_data1)
    );

    task automatic sample_bus(inout obs_t o);
        if (bus_write0) begin
            o.n_wr    = o.n_wr + 1;
            o.wr_addr = bus_addr0;
            o.wr_data = bus_data0;
        end
        if (bus_write1) o.wr_addr1 = bus_addr1;
        if (bus_read0)  o.n_rd = o.n_rd + 1;
    endtask

    task automatic host_cycle(input bit is_addr, input bit is_read, input logic [7:0] wdata,
                              output obs_t o);
        o = '{lat: -1, n_wr: 0, n_rd: 0, rel_cyc: -1, wr_addr: 8'h00, wr_data: 8'h00,
              wr_addr1: 8'h00, rd_val: 8'h00, db_idle: 8'h00, rd_hold_ok: 1'b1};
        @(negedge mclk);
        usb_write = is_read;
        host_db   = wdata;
        host_oe   = !is_read;
        if (is_addr) usb_astb = 1'b0;
        else         usb_dstb = 1'b0;
        for (int c = 1; c <= 40 && o.lat < 0; c++) begin
            @(posedge mclk); #1;
            sample_bus(o);
            if (usb_wait0) o.lat = c;
        end
        o.rd_val = usb_db0;
        repeat (3) begin
            @(posedge mclk); #1;
            sample_bus(o);
            if (usb_db0 !== o.rd_val || usb_wait0 !== 1'b1) o.rd_hold_ok = 1'b0;
        end
        usb_astb = 1'b1;
        usb_dstb = 1'b1;
        for (int c = 1; c <= 10 && o.rel_cyc < 0; c++) begin
            @(posedge mclk); #1;
            sample_bus(o);
            if (!usb_wait0) o.rel_cyc = c;
        end
        host_oe = 1'b0;
        repeat (2) begin
            @(posedge mclk); #1;
            sample_bus(o);
        end
        o.db_idle = usb_db0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        n_tests++; if (usb_wait0 !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b want 0", usb_wait0); end
        n_tests++; if (bus_read0 !== 1'b0) begin n_fail++; $display("FAIL reset_bus_read: got %b want 0", bus_read0); end
        n_tests++; if (bus_write0 !== 1'b0) begin n_fail++; $display("FAIL reset_bus_write: got %b want 0", bus_write0); end
        n_tests++; if (bus_addr0 !== 8'h00) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 00", bus_addr0); end
        n_tests++; if (!($isunknown(usb_db0) || usb_db0 == 8'h00)) begin n_fail++; $display("FAIL reset_usb_db_z: got %h want undriven", usb_db0); end
        n_tests++; if (!($isunknown(bus_data0) || bus_data0 == 8'h00)) begin n_fail++; $display("FAIL reset_bus_data_z: got %h want undriven", bus_data0); end
        @(negedge mclk);
        rst_n = 1'b1;
        repeat (2) @(posedge mclk);
    endtask

    task automatic test_addr();
        obs_t o;
        exp_t e;
        exp_q.push_back('{lat: S+2, n_wr: 0, n_rd: 0, wr_addr: 8'h00, wr_data: 8'h00, rd_val: 8'h00, is_read: 1'b0});
        host_cycle(1'b1, 1'b0, 8'h5A, o);
        e = exp_q.pop_front();
        n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL addr_wr_latency: got %0d want %0d", o.lat, e.lat); end
        n_tests++; if (bus_addr0 !== 8'h5A) begin n_fail++; $display("FAIL addr_wr_bus_addr: got %h want 5a", bus_addr0); end
        n_tests++; if (o.n_wr !== e.n_wr || o.n_rd !== e.n_rd) begin n_fail++; $display("FAIL addr_wr_no_bus: got wr=%0d rd=%0d want 0 0", o.n_wr, o.n_rd); end
        exp_q.push_back('{lat: S+2, n_wr: 0, n_rd: 0, wr_addr: 8'h00, wr_data: 8'h00, rd_val: 8'h5A, is_read: 1'b1});
        host_cycle(1'b1, 1'b1, 8'h00, o);
        e = exp_q.pop_front();
        n_tests++; if (o.rd_val !== e.rd_val || !o.rd_hold_ok) begin n_fail++; $display("FAIL addr_rd_value: got %h hold=%0b want %h", o.rd_val, o.rd_hold_ok, e.rd_val); end
        n_tests++; if (o.n_wr !== e.n_wr || o.n_rd !== e.n_rd) begin n_fail++; $display("FAIL addr_rd_no_bus: got wr=%0d rd=%0d want 0 0", o.n_wr, o.n_rd); end
        n_tests++; if (o.rel_cyc !== S+1) begin n_fail++; $display("FAIL addr_rd_release: got %0d want %0d", o.rel_cyc, S+1); end
        n_tests++; if (!($isunknown(o.db_idle) || o.db_idle == 8'h00)) begin n_fail++; $display("FAIL addr_rd_db_released: got %h want undriven", o.db_idle); end
    endtask

    task automatic test_data_write();
        obs_t o;
        exp_t e;
        host_cycle(1'b1, 1'b0, 8'h10, o);
        exp_q.push_back('{lat: S+2, n_wr: 1, n_rd: 0, wr_addr: 8'h10, wr_data: 8'hC3, rd_val: 8'h00, is_read: 1'b0});
        host_cycle(1'b0, 1'b0, 8'hC3, o);
        e = exp_q.pop_front();
        n_tests++; if (o.n_wr !== e.n_wr) begin n_fail++; $display("FAIL dwr_pulse_count: got %0d want %0d", o.n_wr, e.n_wr); end
        n_tests++; if (o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data) begin n_fail++; $display("FAIL dwr_bus_values: got %h/%h want %h/%h", o.wr_addr, o.wr_data, e.wr_addr, e.wr_data); end
        n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL dwr_latency: got %0d want %0d", o.lat, e.lat); end
        n_tests++; if (o.n_rd !== e.n_rd) begin n_fail++; $display("FAIL dwr_no_read: got %0d want 0", o.n_rd); end
    endtask

    task automatic test_data_read();
        obs_t o;
        exp_t e;
        bm_val = 8'h7E;
        exp_q.push_back('{lat: S+1+RL, n_wr: 0, n_rd: RL, wr_addr: 8'h00, wr_data: 8'h00, rd_val: 8'h7E, is_read: 1'b1});
        host_cycle(1'b0, 1'b1, 8'h00, o);
        e = exp_q.pop_front();
        n_tests++; if (o.n_rd !== e.n_rd) begin n_fail++; $display("FAIL drd_read_cycles: got %0d want %0d", o.n_rd, e.n_rd); end
        n_tests++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL drd_latency: got %0d want %0d", o.lat, e.lat); end
        n_tests++; if (o.rd_val !== e.rd_val || !o.rd_hold_ok) begin n_fail++; $display("FAIL drd_value: got %h hold=%0b want %h", o.rd_val, o.rd_hold_ok, e.rd_val); end
        n_tests++; if (o.n_wr !== e.n_wr) begin n_fail++; $display("FAIL drd_no_write: got %0d want 0", o.n_wr); end
        n_tests++; if (!($isunknown(o.db_idle) || o.db_idle == 8'h00)) begin n_fail++; $display("FAIL drd_db_released: got %h want undriven", o.db_idle); end
    endtask

    task automatic test_back_to_back();
        obs_t       o;
        exp_t       e;
        bit         op_rd[6];
        logic [7:0] op_val[6];
        for (int i = 0; i < 6; i++) begin
            op_rd[i]  = (i % 2) == 1;
            op_val[i] = 8'($urandom_range(1, 255));
            if (op_rd[i])
                exp_q.push_back('{lat: S+1+RL, n_wr: 0, n_rd: RL, wr_addr: 8'h00, wr_data: 8'h00, rd_val: op_val[i], is_read: 1'b1});
            else
                exp_q.push_back('{lat: S+2, n_wr: 1, n_rd: 0, wr_addr: 8'h10, wr_data: op_val[i], rd_val: 8'h00, is_read: 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            bm_val = op_val[i];
            host_cycle(1'b0, op_rd[i], op_val[i], o);
            e = exp_q.pop_front();
            n_tests++;
            if (o.lat !== e.lat || o.n_wr !== e.n_wr || o.n_rd !== e.n_rd ||
                (e.is_read && o.rd_val !== e.rd_val) ||
                (!e.is_read && (o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data))) begin
                n_fail++;
                $display("FAIL b2b_%0d: got lat=%0d wr=%0d rd=%0d a=%h d=%h r=%h want lat=%0d wr=%0d rd=%0d a=%h d=%h r=%h",
                         i, o.lat, o.n_wr, o.n_rd, o.wr_addr, o.wr_data, o.rd_val,
                         e.lat, e.n_wr, e.n_rd, e.wr_addr, e.wr_data, e.rd_val);
            end
        end
    endtask

    task automatic test_auto_inc();
        obs_t o;
        host_cycle(1'b1, 1'b0, 8'hFF, o);
        host_cycle(1'b0, 1'b0, 8'h11, o);
        n_tests++; if (o.wr_addr1 !== 8'hFF) begin n_fail++; $display("FAIL autoinc_first: got %h want ff", o.wr_addr1); end
        host_cycle(1'b0, 1'b0, 8'h22, o);
        n_tests++; if (o.wr_addr1 !== 8'h00) begin n_fail++; $display("FAIL autoinc_wrap: got %h want 00", o.wr_addr1); end
        n_tests++; if (o.wr_addr !== 8'hFF) begin n_fail++; $display("FAIL no_autoinc_addr: got %h want ff", o.wr_addr); end
    endtask

    task automatic test_both_strobes();
        bit bad = 1'b0;
        @(negedge mclk);
        usb_write = 1'b0;
        host_db   = 8'h66;
        host_oe   = 1'b1;
        usb_astb  = 1'b0;
        usb_dstb  = 1'b0;
        repeat (10) begin
            @(posedge mclk); #1;
            if (usb_wait0 || usb_wait1 || bus_write0 || bus_read0) bad = 1'b1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL both_strobes_ignored: got activity want none"); end
        n_tests++; if (bus_addr0 !== 8'hFF) begin n_fail++; $display("FAIL both_strobes_addr: got %h want ff", bus_addr0); end
        usb_astb = 1'b1;
        usb_dstb = 1'b1;
        host_oe  = 1'b0;
        repeat (4) @(posedge mclk);
    endtask

    task automatic test_reset_mid_read();
        obs_t o;
        exp_t e;
        bit   seen = 1'b0;
        bm_val = 8'hA7;
        @(negedge mclk);
        usb_write = 1'b1;
        usb_dstb  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge mclk); #1;
            if (bus_read0) seen = 1'b1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL midrd_enter: got no bus_read want bus_read"); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus_read0 !== 1'b0 || usb_wait0 !== 1'b0) begin n_fail++; $display("FAIL midrd_abort: got rd=%b wait=%b want 0 0", bus_read0, usb_wait0); end
        n_tests++; if (!(($isunknown(usb_db0) || usb_db0 == 8'h00) && ($isunknown(bus_data0) || bus_data0 == 8'h00))) begin n_fail++; $display("FAIL midrd_tristate: got db=%h data=%h want undriven", usb_db0, bus_data0); end
        usb_dstb = 1'b1;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        rst_n = 1'b1;
        repeat (2) @(posedge mclk);
        bm_val = 8'h9C;
        exp_q.push_back('{lat: S+1+RL, n_wr: 0, n_rd: RL, wr_addr: 8'h00, wr_data: 8'h00, rd_val: 8'h9C, is_read: 1'b1});
        host_cycle(1'b0, 1'b1, 8'h00, o);
        e = exp_q.pop_front();
        n_tests++; if (o.rd_val !== e.rd_val || o.lat !== e.lat || o.n_rd !== e.n_rd) begin n_fail++; $display("FAIL midrd_recover: got %h lat=%0d rd=%0d want %h lat=%0d rd=%0d", o.rd_val, o.lat, o.n_rd, e.rd_val, e.lat, e.n_rd); end
        n_tests++; if (bus_addr0 !== 8'h00) begin n_fail++; $display("FAIL midrd_addr_reset: got %h want 00", bus_addr0); end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_data_write();
        test_data_read();
        test_back_to_back();
        test_auto_inc();
        test_both_strobes();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
